div_clk_monitor: RTL and testbench

//  Receive side of the divided-clock path: samples the slow divided clock (div-by-6, toggles every
//  3 fast cycles) in the fast clk_i domain. Emits one-cycle rise/fall strobes for use as clock

---
 rtl/div_clk_monitor.sv | 141 ++++++++++++++
 tb/tb_div_clk_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// Fast-domain receiver for a divided clock: synchronizes it, emits edge strobes,
// measures half-periods and tracks lock, flagging and counting each loss of lock.
`timescale 1ns/1ps

module div_clk_monitor #(
    parameter int HALF_PERIOD = 3,
    parameter int TOL         = 0,
    parameter int LOCK_COUNT  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             div_clk_i,
    input  logic             clear_i,
    output logic             rise_o,
    output logic             fall_o,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]   TIMEOUT_VAL = CNT_W'(HALF_PERIOD + TOL + 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(LOCK_COUNT);
    localparam logic signed [CNT_W:0] HP_S  = (CNT_W+1)'(HALF_PERIOD);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

    logic               s1_reg, s2_reg, s3_reg;
    logic               rise_reg, fall_reg, err_reg;
    logic [CNT_W-1:0]   hp_cnt_reg, period_reg, err_cnt_reg;
    logic [1:0]         state_reg, state_next;
    logic [MATCH_W-1:0] match_reg, match_next;
    logic               err_next;

    logic               edge_det;
    logic               good;
    logic               timeout;
    logic signed [CNT_W:0] diff;

    assign edge_det = s2_reg ^ s3_reg;

    // Signed difference so a short half-period compares correctly against -TOL.
    assign diff    = $signed({1'b0, hp_cnt_reg}) - HP_S;
    assign good    = (diff <= TOL_S) && (diff >= -TOL_S);
    assign timeout = (state_reg != ST_IDLE) && !edge_det && (hp_cnt_reg == TIMEOUT_VAL);

    always_comb begin
        state_next = state_reg;
        match_next = match_reg;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (edge_det) begin
                    state_next = ST_ACQUIRE;
                    match_next = '0;
                end
            end
            ST_ACQUIRE: begin
                if (edge_det && good) begin
                    if (match_reg + 1'b1 == MATCH_LAST) begin
                        state_next = ST_LOCKED;
                        match_next = '0;
                    end else begin
                        match_next = match_reg + 1'b1;
                    end
                end else if (edge_det || timeout) begin
                    match_next = '0;
                end
            end
            ST_LOCKED: begin
                if ((edge_det && !good) || timeout) begin
                    state_next = ST_ACQUIRE;
                    match_next = '0;
                    err_next   = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                match_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_reg      <= 1'b0;
            s2_reg      <= 1'b0;
            s3_reg      <= 1'b0;
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
            err_reg     <= 1'b0;
            hp_cnt_reg  <= '0;
            period_reg  <= '0;
            err_cnt_reg <= '0;
            state_reg   <= ST_IDLE;
            match_reg   <= '0;
        end else begin
            s1_reg    <= div_clk_i;
            s2_reg    <= s1_reg;
            s3_reg    <= s2_reg;
            rise_reg  <= s2_reg & ~s3_reg;
            fall_reg  <= ~s2_reg & s3_reg;
            err_reg   <= err_next;
            state_reg <= state_next;
            match_reg <= match_next;

            if (edge_det) begin
                hp_cnt_reg <= CNT_W'(1);
            end else if (hp_cnt_reg != CNT_MAX) begin
                hp_cnt_reg <= hp_cnt_reg + 1'b1;
            end

            // The first edge after reset has no preceding edge to measure from.
            if (edge_det && state_reg != ST_IDLE) begin
                period_reg <= hp_cnt_reg;
            end

            // Counts the registered strobe, so a clear in the strobe cycle still keeps it.
            if (clear_i) begin
                err_cnt_reg <= {{(CNT_W-1){1'b0}}, err_reg};
            end else if (err_reg && err_cnt_reg != CNT_MAX) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign rise_o    = rise_reg;
    assign fall_o    = fall_reg;
    assign err_o     = err_reg;
    assign locked_o  = (state_reg == ST_LOCKED);
    assign period_o  = period_reg;
    assign err_cnt_o = err_cnt_reg;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor: a cycle table for acquisition from reset,
// then hand sequences for long/short/stalled half-periods, clearing, saturation and reset.
`timescale 1ns/1ps

module tb_div_clk_monitor;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       div_clk, div_t;
    logic       clear;
    logic       rise, fall, locked, err;
    logic [7:0] period, err_cnt;
    logic       rise_t, fall_t, locked_t, err_t;
    logic [7:0] period_t, err_cnt_t;

    int n_tests = 0;
    int n_fail  = 0;
    int err_seen = 0;
    int err_seen_t = 0;

    always #5 clk = ~clk;

    div_clk_monitor dut (
        .clk_i(clk), .reset_ni(reset_n), .div_clk_i(div_clk), .clear_i(clear),
        .rise_o(rise), .fall_o(fall), .locked_o(locked), .err_o(err),
        .period_o(period), .err_cnt_o(err_cnt)
    );

    div_clk_monitor #(.TOL(1)) dut_t (
        .clk_i(clk), .reset_ni(reset_n), .div_clk_i(div_t), .clear_i(1'b0),
        .rise_o(rise_t), .fall_o(fall_t), .locked_o(locked_t), .err_o(err_t),
        .period_o(period_t), .err_cnt_o(err_cnt_t)
    );

    typedef struct {
        logic       div;
        logic       rise;
        logic       fall;
        logic       locked;
        logic       err;
        logic [7:0] period;
        logic [7:0] err_cnt;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        err_seen   += int'(err);
        err_seen_t += int'(err_t);
    endtask

    task automatic half(input int len);
        div_clk = ~div_clk;
        repeat (len) cyc();
    endtask

    task automatic half_t(input int len);
        div_t = ~div_t;
        repeat (len) cyc();
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 20; i++) begin
            div_clk = vecs[i].div;
            cyc();
            $display("[TB] %s cycle %0d div=%b rise=%b fall=%b locked=%b err=%b period=%0d err_cnt=%0d",
                     tag, i + 1, vecs[i].div, rise, fall, locked, err, period, err_cnt);
            check($sformatf("%s_c%0d_rise", tag, i + 1), rise, vecs[i].rise);
            check($sformatf("%s_c%0d_fall", tag, i + 1), fall, vecs[i].fall);
            check($sformatf("%s_c%0d_locked", tag, i + 1), locked, vecs[i].locked);
            check($sformatf("%s_c%0d_err", tag, i + 1), err, vecs[i].err);
            check($sformatf("%s_c%0d_period", tag, i + 1), period, vecs[i].period);
            check($sformatf("%s_c%0d_err_cnt", tag, i + 1), err_cnt, vecs[i].err_cnt);
        end
    endtask

    initial begin
        // div toggles every 3 cycles; first change sampled at cycle 4 -> rise at 6,
        // first measured edge shows period 3 at cycle 9, fourth good edge locks at 18.
        //            div rise fall lock err period cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0};

        reset_n = 1'b0;
        div_clk = 1'b0;
        div_t   = 1'b0;
        clear   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rise", rise, 1'b0);
        check("reset_locked", locked, 1'b0);
        check("reset_period", period, 8'd0);
        check("reset_err_cnt", err_cnt, 8'd0);
        reset_n = 1'b1;

        // Acquisition from reset.
        run_table("acq");

        // One 5-cycle half-period while locked: error at timeout, late edge measures 5.
        cyc();
        err_seen = 0;
        half(5);
        half(3);
        $display("[TB] long half: err_seen=%0d locked=%b err_cnt=%0d period=%0d", err_seen, locked, err_cnt, period);
        check("long_err_pulses", err_seen, 1);
        check("long_unlocked", locked, 1'b0);
        check("long_err_cnt", err_cnt, 8'd1);
        check("long_period", period, 8'd5);
        repeat (3) half(3);
        check("relock_not_yet", locked, 1'b0);
        half(3);
        $display("[TB] relock after long half: locked=%b", locked);
        check("relock_long", locked, 1'b1);

        // Static divided clock: a single timeout error, then a saturated measurement.
        err_seen = 0;
        repeat (300) cyc();
        $display("[TB] stall: err_seen=%0d locked=%b err_cnt=%0d", err_seen, locked, err_cnt);
        check("stall_err_pulses", err_seen, 1);
        check("stall_unlocked", locked, 1'b0);
        check("stall_err_cnt", err_cnt, 8'd2);
        half(3);
        check("stall_period_sat", period, 8'd255);
        check("stall_no_second_err", err_seen, 1);
        repeat (4) half(3);
        $display("[TB] relock after stall: locked=%b period=%0d", locked, period);
        check("relock_stall", locked, 1'b1);

        // Short half-period errors on its edge; clear lands in the strobe cycle.
        half(2);
        div_clk = ~div_clk;
        cyc();
        cyc();
        cyc();
        check("short_err_strobe", err, 1'b1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        $display("[TB] clear with err: err_cnt=%0d", err_cnt);
        check("clear_with_err", err_cnt, 8'd1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("clear_alone", err_cnt, 8'd0);
        repeat (5) half(3);
        check("relock_short", locked, 1'b1);

        // 300 short-half errors, relocking in between: counter holds at 255.
        err_seen = 0;
        for (int i = 0; i < 300; i++) begin
            half(2);
            repeat (5) half(3);
        end
        $display("[TB] saturation: err_seen=%0d err_cnt=%0d locked=%b", err_seen, err_cnt, locked);
        check("sat_err_pulses", err_seen, 300);
        check("sat_err_cnt", err_cnt, 8'd255);
        check("sat_locked", locked, 1'b1);

        // Asynchronous reset between clock edges while locked.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        $display("[TB] async reset: locked=%b period=%0d err_cnt=%0d", locked, period, err_cnt);
        check("areset_rise", rise, 1'b0);
        check("areset_fall", fall, 1'b0);
        check("areset_locked", locked, 1'b0);
        check("areset_err", err, 1'b0);
        check("areset_period", period, 8'd0);
        check("areset_err_cnt", err_cnt, 8'd0);
        div_clk = 1'b0;
        div_t   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        err_seen = 0;
        err_seen_t = 0;
        run_table("reacq");
        check("reacq_no_err", err_seen, 0);

        // TOL=1 instance: alternating 2/4 half-periods lock; a 1-cycle half errors on its edge.
        half_t(2);
        half_t(4);
        half_t(2);
        half_t(4);
        check("tol_not_locked", locked_t, 1'b0);
        half_t(2);
        half_t(4);
        $display("[TB] tol: locked=%b period=%0d", locked_t, period_t);
        check("tol_locked", locked_t, 1'b1);
        check("tol_period2", period_t, 8'd2);
        half_t(4);
        check("tol_period4", period_t, 8'd4);
        check("tol_no_err", err_seen_t, 0);
        half_t(1);
        half_t(3);
        $display("[TB] tol short: err_seen=%0d locked=%b period=%0d", err_seen_t, locked_t, period_t);
        check("tol_short_err", err_seen_t, 1);
        check("tol_short_unlocked", locked_t, 1'b0);
        check("tol_short_period", period_t, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
